// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Ports: clk_i, rst_n_i (sync, active low); ID-side controls/data (*_i);
//   hold_i freezes all state, flush_i squashes the ID instruction;
//   EX-side registered copies (*_o, imm_ext_o extended at capture);
//   stall_o comb load-use request, bubble_cnt_o saturating bubble count.
// Optional feature: define LOAD_USE_DETECT_EN to enable hazard detection.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  input  logic        RegDst_i,
  input  logic        ALUSrc_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  input  logic        MemWrite_i,
  input  logic        Branch_i,
  input  logic        ExtOp_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [15:0] imm_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic        RegDst_o,
  output logic        ALUSrc_o,
  output logic        MemtoReg_o,
  output logic        RegWrite_o,
  output logic        MemWrite_o,
  output logic [1:0]  ALUOp_o,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  output logic [31:0] imm_ext_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  funct_o,
  output logic        stall_o,
  output logic [15:0] bubble_cnt_o
);

  logic hazard;
  logic [31:0] imm_ext;

  assign imm_ext = ExtOp_i ? {{16{imm_i[15]}}, imm_i}
                           : {16'b0, imm_i};

`ifdef LOAD_USE_DETECT_EN
  logic reads_rt;
  logic ex_load;

  // rt is a source only for R-type, stores and branches
  assign reads_rt = RegDst_i | MemWrite_i | Branch_i;
  assign ex_load  = valid_o & MemtoReg_o & RegWrite_o
                  & (rt_o != 5'd0);
  assign hazard   = rst_n_i & ex_load & valid_i
                  & ((rt_o == rs_i)
                  | (reads_rt & (rt_o == rt_i)));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bubble_cnt_o <= 16'd0;
    end else if (!hold_i && !flush_i && hazard
                 && bubble_cnt_o != 16'hFFFF) begin
      bubble_cnt_o <= bubble_cnt_o + 16'd1;
    end
  end
`else
  logic unused_branch;

  assign unused_branch = Branch_i;
  assign hazard        = 1'b0;
  assign bubble_cnt_o  = 16'd0;
`endif

  assign stall_o = hazard;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_o    <= 1'b0;
      RegDst_o   <= 1'b0;
      ALUSrc_o   <= 1'b0;
      MemtoReg_o <= 1'b0;
      RegWrite_o <= 1'b0;
      MemWrite_o <= 1'b0;
      ALUOp_o    <= 2'd0;
      rs_data_o  <= 32'd0;
      rt_data_o  <= 32'd0;
      imm_ext_o  <= 32'd0;
      rs_o       <= 5'd0;
      rt_o       <= 5'd0;
      rd_o       <= 5'd0;
      funct_o    <= 6'd0;
    end else if (!hold_i) begin
      if (flush_i || hazard) begin
        // squash or bubble: data fields left as don't-care
        valid_o    <= 1'b0;
        RegWrite_o <= 1'b0;
        MemWrite_o <= 1'b0;
      end else begin
        valid_o    <= valid_i;
        RegDst_o   <= RegDst_i;
        ALUSrc_o   <= ALUSrc_i;
        MemtoReg_o <= MemtoReg_i;
        RegWrite_o <= RegWrite_i & valid_i;
        MemWrite_o <= MemWrite_i & valid_i;
        ALUOp_o    <= ALUOp_i;
        rs_data_o  <= rs_data_i;
        rt_data_o  <= rt_data_i;
        imm_ext_o  <= imm_ext;
        rs_o       <= rs_i;
        rt_o       <= rt_i;
        rd_o       <= rd_i;
        funct_o    <= funct_i;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hazard
// sequences and randomized traffic against a behavioural model.
module tb_id_ex_stage;

`ifdef LOAD_USE_DETECT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, regdst, alusrc, mtr, rw, mw, branch, extop;
  logic [1:0]  aluop;
  logic [31:0] rsd, rtd;
  logic [15:0] imm;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic        hold, flush;
  logic        valid_o, regdst_o, alusrc_o, mtr_o, rw_o, mw_o;
  logic [1:0]  aluop_o;
  logic [31:0] rsd_o, rtd_o, imm_o;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [5:0]  funct_o;
  logic        stall;
  logic [15:0] cnt;

  id_ex_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid),
    .RegDst_i(regdst), .ALUSrc_i(alusrc), .MemtoReg_i(mtr),
    .RegWrite_i(rw), .MemWrite_i(mw), .Branch_i(branch),
    .ExtOp_i(extop), .ALUOp_i(aluop), .rs_data_i(rsd),
    .rt_data_i(rtd), .imm_i(imm), .rs_i(rs), .rt_i(rt),
    .rd_i(rd), .funct_i(funct), .hold_i(hold), .flush_i(flush),
    .valid_o(valid_o), .RegDst_o(regdst_o), .ALUSrc_o(alusrc_o),
    .MemtoReg_o(mtr_o), .RegWrite_o(rw_o), .MemWrite_o(mw_o),
    .ALUOp_o(aluop_o), .rs_data_o(rsd_o), .rt_data_o(rtd_o),
    .imm_ext_o(imm_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
    .funct_o(funct_o), .stall_o(stall), .bubble_cnt_o(cnt)
  );

  typedef struct {
    logic rst_n, valid, regdst, alusrc, mtr, rw, mw, branch, extop;
    logic [1:0]  aluop;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic hold, flush;
  } in_t;

  typedef struct {
    in_t         in;
    logic        stall, valid, rw, mw, chk_imm;
    logic [31:0] imm;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic valid, regdst, alusrc, mtr, rw, mw;
    logic [1:0]  aluop;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
  } ex_t;

  int   passed = 0;
  int   total  = 0;
  ex_t  m;
  int   mcnt;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic in_t nop();
    in_t v;
    v = '{rst_n: 1'b1, aluop: 2'd0, rsd: 32'd0, rtd: 32'd0,
          imm: 16'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, funct: 6'd0,
          default: 1'b0};
    return v;
  endfunction

  function automatic in_t lw(input logic [4:0] t);
    in_t v = nop();
    v.valid = 1; v.alusrc = 1; v.mtr = 1; v.rw = 1; v.extop = 1;
    v.rs = 5'd1; v.rt = t; v.imm = 16'd4; v.rsd = 32'h1000;
    return v;
  endfunction

  function automatic in_t rtype(input logic [4:0] s, t, d);
    in_t v = nop();
    v.valid = 1; v.regdst = 1; v.rw = 1; v.aluop = 2'd2;
    v.rs = s; v.rt = t; v.rd = d; v.funct = 6'h20;
    v.rsd = 32'h11; v.rtd = 32'h22;
    return v;
  endfunction

  function automatic in_t ori(input logic [4:0] s, t,
                              input logic [15:0] i, input logic e);
    in_t v = nop();
    v.valid = 1; v.alusrc = 1; v.rw = 1; v.extop = e; v.aluop = 2'd3;
    v.rs = s; v.rt = t; v.imm = i;
    return v;
  endfunction

  function automatic in_t sw(input logic [4:0] s, t);
    in_t v = nop();
    v.valid = 1; v.alusrc = 1; v.mw = 1; v.extop = 1;
    v.rs = s; v.rt = t; v.imm = 16'd8;
    return v;
  endfunction

  function automatic void addv(input in_t v, input logic s, vl,
                               input logic w, x, ci,
                               input logic [31:0] i,
                               input logic [15:0] c);
    vec_t r;
    r.in = v; r.stall = s; r.valid = vl; r.rw = w; r.mw = x;
    r.chk_imm = ci; r.imm = i; r.cnt = c;
    tbl.push_back(r);
  endfunction

  task automatic apply(input in_t v);
    rst_n = v.rst_n; valid = v.valid; regdst = v.regdst;
    alusrc = v.alusrc; mtr = v.mtr; rw = v.rw; mw = v.mw;
    branch = v.branch; extop = v.extop; aluop = v.aluop;
    rsd = v.rsd; rtd = v.rtd; imm = v.imm; rs = v.rs; rt = v.rt;
    rd = v.rd; funct = v.funct; hold = v.hold; flush = v.flush;
  endtask

  // Reference: hazard when EX holds a real load to a nonzero register
  // and the ID instruction consumes that register.
  function automatic logic model_stall(input in_t v);
    logic uses_rt;
    if (!EN || !v.rst_n) return 1'b0;
    uses_rt = v.regdst || v.mw || v.branch;
    return m.valid && m.mtr && m.rw && m.rt != 0 && v.valid &&
           (m.rt == v.rs || (uses_rt && m.rt == v.rt));
  endfunction

  function automatic void model_step(input in_t v);
    logic hz = model_stall(v);
    if (!v.rst_n) begin
      m = '{aluop: 2'd0, rsd: 32'd0, rtd: 32'd0, imm: 32'd0,
            rs: 5'd0, rt: 5'd0, rd: 5'd0, funct: 6'd0, default: 1'b0};
      mcnt = 0;
    end else if (v.hold) begin
    end else if (v.flush || hz) begin
      m.valid = 0; m.rw = 0; m.mw = 0;
      if (!v.flush && mcnt < 65535) mcnt = mcnt + 1;
    end else begin
      m.valid = v.valid; m.regdst = v.regdst; m.alusrc = v.alusrc;
      m.mtr = v.mtr; m.rw = v.rw && v.valid; m.mw = v.mw && v.valid;
      m.aluop = v.aluop; m.rsd = v.rsd; m.rtd = v.rtd;
      m.imm = v.extop ? 32'($signed(v.imm)) : {16'd0, v.imm};
      m.rs = v.rs; m.rt = v.rt; m.rd = v.rd; m.funct = v.funct;
    end
  endfunction

  initial begin
    in_t v;
    logic e = EN;
    logic ne = !EN;
    logic [15:0] c1 = {15'd0, e};
    logic [15:0] c2 = {14'd0, e, 1'b0};

    v = rtype(5'd1, 5'd2, 5'd3); v.rst_n = 0;
    addv(v, 0, 0, 0, 0, 1, 32'd0, 16'd0);
    addv(ori(5'd1, 5'd2, 16'h8001, 0), 0, 1, 1, 0, 1, 32'h00008001, 0);
    addv(ori(5'd1, 5'd2, 16'h8001, 1), 0, 1, 1, 0, 1, 32'hFFFF8001, 0);
    addv(lw(5'd8), 0, 1, 1, 0, 1, 32'd4, 0);
    addv(rtype(5'd8, 5'd9, 5'd10), e, ne, ne, 0, 0, 32'd0, c1);
    addv(rtype(5'd8, 5'd9, 5'd10), 0, 1, 1, 0, 1, 32'd0, c1);
    addv(lw(5'd0), 0, 1, 1, 0, 1, 32'd4, c1);
    addv(rtype(5'd0, 5'd0, 5'd5), 0, 1, 1, 0, 1, 32'd0, c1);
    addv(lw(5'd8), 0, 1, 1, 0, 1, 32'd4, c1);
    addv(ori(5'd1, 5'd8, 16'h0010, 0), 0, 1, 1, 0, 1, 32'h10, c1);
    addv(lw(5'd8), 0, 1, 1, 0, 1, 32'd4, c1);
    v = rtype(5'd8, 5'd9, 5'd10); v.hold = 1;
    addv(v, e, 1, 1, 0, 1, 32'd4, c1);
    v = rtype(5'd8, 5'd9, 5'd10); v.flush = 1;
    addv(v, e, 0, 0, 0, 0, 32'd0, c1);
    addv(lw(5'd8), 0, 1, 1, 0, 1, 32'd4, c1);
    addv(sw(5'd1, 5'd8), e, ne, 0, ne, 0, 32'd0, c2);
    addv(sw(5'd1, 5'd8), 0, 1, 0, 1, 1, 32'd8, c2);
    addv(lw(5'd8), 0, 1, 1, 0, 1, 32'd4, c2);
    v = rtype(5'd8, 5'd9, 5'd10); v.rst_n = 0;
    addv(v, 0, 0, 0, 0, 1, 32'd0, 0);
    addv(rtype(5'd8, 5'd9, 5'd10), 0, 1, 1, 0, 1, 32'd0, 0);
    v = rtype(5'd8, 5'd9, 5'd10); v.valid = 0; v.mw = 1;
    addv(v, 0, 0, 0, 0, 0, 32'd0, 0);
    addv(lw(5'd8), 0, 1, 1, 0, 1, 32'd4, 0);
    v = nop(); v.valid = 1; v.branch = 1; v.rs = 5'd3; v.rt = 5'd8;
    addv(v, e, ne, 0, 0, 0, 32'd0, c1);

    apply(nop());
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i].in);
      #1;
      chk($sformatf("v%0d stall", i), 64'(stall), 64'(tbl[i].stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid", i), 64'(valid_o), 64'(tbl[i].valid));
      chk($sformatf("v%0d regwrite", i), 64'(rw_o), 64'(tbl[i].rw));
      chk($sformatf("v%0d memwrite", i), 64'(mw_o), 64'(tbl[i].mw));
      chk($sformatf("v%0d bubbles", i), 64'(cnt), 64'(tbl[i].cnt));
      if (tbl[i].chk_imm)
        chk($sformatf("v%0d imm", i), 64'(imm_o), 64'(tbl[i].imm));
    end

`ifdef LOAD_USE_DETECT_EN
    // Drive the counter to saturation with back-to-back load-use pairs.
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk); apply(lw(5'd8));
      @(negedge clk); apply(rtype(5'd8, 5'd9, 5'd10));
      if (i == 65534) begin
        @(posedge clk); #1;
        chk("sat preload", 64'(cnt), 64'hFFFF);
      end
    end
    @(posedge clk); #1;
    chk("sat hold", 64'(cnt), 64'hFFFF);
`endif

    // Randomized traffic against the model, starting from reset.
    for (int i = 0; i < 3000; i++) begin
      v = nop();
      v.rst_n  = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      v.valid  = $urandom_range(0, 9) != 0;
      v.regdst = $urandom_range(0, 1) == 1;
      v.alusrc = $urandom_range(0, 1) == 1;
      v.mtr    = $urandom_range(0, 2) == 0;
      v.rw     = $urandom_range(0, 3) != 0;
      v.mw     = $urandom_range(0, 4) == 0;
      v.branch = $urandom_range(0, 4) == 0;
      v.extop  = $urandom_range(0, 1) == 1;
      v.aluop  = 2'($urandom);
      v.rsd    = $urandom;
      v.rtd    = $urandom;
      v.imm    = 16'($urandom);
      v.rs     = 5'($urandom_range(0, 3));
      v.rt     = 5'($urandom_range(0, 3));
      v.rd     = 5'($urandom);
      v.funct  = 6'($urandom);
      v.hold   = $urandom_range(0, 9) == 0;
      v.flush  = $urandom_range(0, 9) == 0;
      @(negedge clk);
      apply(v);
      #1;
      if (i > 0) chk("rand stall", 64'(stall), 64'(model_stall(v)));
      @(posedge clk);
      model_step(v);
      #1;
      chk("rand valid", 64'(valid_o), 64'(m.valid));
      chk("rand regwrite", 64'(rw_o), 64'(m.rw));
      chk("rand memwrite", 64'(mw_o), 64'(m.mw));
      chk("rand bubbles", 64'(cnt), 64'(mcnt));
      if (m.valid) begin
        chk("rand ctl",
            64'({regdst_o, alusrc_o, mtr_o, aluop_o, funct_o}),
            64'({m.regdst, m.alusrc, m.mtr, m.aluop, m.funct}));
        chk("rand regs", 64'({rs_o, rt_o, rd_o}),
            64'({m.rs, m.rt, m.rd}));
        chk("rand data", {rsd_o, rtd_o}, {m.rsd, m.rtd});
        chk("rand imm", 64'(imm_o), 64'(m.imm));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
